// File: rtl/alu_mp_sequencer.sv
// Multi-precision add/sub sequencer: drives a 32-bit combinational alu one limb per cycle, LS limb first.
// Latency: response valid WORDS cycles after the request is accepted; issue interval >= WORDS+2 cycles.
// Backpressure: req_ready only in IDLE; DONE holds result until rsp_ready, later requests wait.
module alu_mp_sequencer #(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_op,
    input  logic [WORDS*32-1:0]   req_a,
    input  logic [WORDS*32-1:0]   req_b,
    input  logic                  req_cin,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WORDS*32-1:0]   rsp_result,
    output logic                  rsp_cout,
    output logic [31:0]           alu_a,
    output logic [31:0]           alu_b,
    output logic [3:0]            alu_sel,
    output logic                  alu_cin,
    input  logic [31:0]           alu_out,
    input  logic                  alu_cout
);

    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IDXW-1:0] idx;
    logic            op_sub;
    logic            carry;
    logic            last_limb;
    logic [31:0]     a_limb   [WORDS];
    logic [31:0]     b_limb   [WORDS];
    logic [31:0]     res_limb [WORDS];

    assign last_limb = (idx == LAST_IDX);

    // Flatten the per-limb result registers onto the response bus.
    for (genvar g = 0; g < WORDS; g++) begin : g_pack
        assign rsp_result[g*32 +: 32] = res_limb[g];
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake/alu drive; alu inputs are forced to zero outside RUN.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        alu_a     = 32'd0;
        alu_b     = 32'd0;
        alu_sel   = 4'b0000;
        alu_cin   = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                alu_a   = a_limb[idx];
                alu_b   = b_limb[idx];
                alu_sel = {3'b000, op_sub};
                alu_cin = carry;
                if (last_limb) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand capture in IDLE, limb-by-limb result and carry chaining in RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            op_sub   <= 1'b0;
            carry    <= 1'b0;
            rsp_cout <= 1'b0;
            for (int i = 0; i < WORDS; i++) begin
                a_limb[i]   <= 32'd0;
                b_limb[i]   <= 32'd0;
                res_limb[i] <= 32'd0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op_sub <= req_op;
                        carry  <= req_cin;
                        idx    <= '0;
                        for (int i = 0; i < WORDS; i++) begin
                            a_limb[i] <= req_a[i*32 +: 32];
                            b_limb[i] <= req_b[i*32 +: 32];
                        end
                    end
                end
                S_RUN: begin
                    res_limb[idx] <= alu_out;
                    carry         <= alu_cout;
                    if (last_limb) begin
                        // Park idx at zero so it never steps past the last limb.
                        rsp_cout <= alu_cout;
                        idx      <= '0;
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mp_sequencer.sv
// Scoreboard bench for alu_mp_sequencer: WORDS=4 and WORDS=1 instances, each with a behavioural alu.
// Expected full-width results are computed at request time and compared when the response is taken.
// Covers carry/borrow chains, DONE backpressure, ignored requests, mid-run reset and single-limb case.
module tb_alu_mp_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // WORDS=4 instance
    logic         req_valid, req_ready, req_op, req_cin;
    logic [127:0] req_a, req_b, rsp_result;
    logic         rsp_valid, rsp_ready, rsp_cout;
    logic [31:0]  alu_a, alu_b, alu_out;
    logic [3:0]   alu_sel;
    logic         alu_cin, alu_cout;

    // WORDS=1 instance
    logic         r1_req_valid, r1_req_ready, r1_req_op, r1_req_cin;
    logic [31:0]  r1_req_a, r1_req_b, r1_rsp_result;
    logic         r1_rsp_valid, r1_rsp_ready, r1_rsp_cout;
    logic [31:0]  r1_alu_a, r1_alu_b, r1_alu_out;
    logic [3:0]   r1_alu_sel;
    logic         r1_alu_cin, r1_alu_cout;

    alu_mp_sequencer #(.WORDS(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_cout(rsp_cout),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_cin(alu_cin),
        .alu_out(alu_out), .alu_cout(alu_cout)
    );

    alu_mp_sequencer #(.WORDS(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(r1_req_valid), .req_ready(r1_req_ready), .req_op(r1_req_op),
        .req_a(r1_req_a), .req_b(r1_req_b), .req_cin(r1_req_cin),
        .rsp_valid(r1_rsp_valid), .rsp_ready(r1_rsp_ready),
        .rsp_result(r1_rsp_result), .rsp_cout(r1_rsp_cout),
        .alu_a(r1_alu_a), .alu_b(r1_alu_b), .alu_sel(r1_alu_sel), .alu_cin(r1_alu_cin),
        .alu_out(r1_alu_out), .alu_cout(r1_alu_cout)
    );

    // Behavioural 32-bit alu: sel 1 = subtract with borrow, otherwise add with carry.
    function automatic logic [32:0] alu_model(input logic [3:0] sel, input logic [31:0] a,
                                              input logic [31:0] b, input logic cin);
        if (sel == 4'b0001) return {1'b0, a} - {1'b0, b} - {32'd0, cin};
        return {1'b0, a} + {1'b0, b} + {32'd0, cin};
    endfunction

    assign {alu_cout, alu_out}       = alu_model(alu_sel, alu_a, alu_b, alu_cin);
    assign {r1_alu_cout, r1_alu_out} = alu_model(r1_alu_sel, r1_alu_a, r1_alu_b, r1_alu_cin);

    typedef struct packed {
        logic [127:0] res;
        logic         cout;
    } exp_t;

    exp_t q4[$];
    exp_t q1[$];

    function automatic exp_t ref4(input logic op, input logic [127:0] a, input logic [127:0] b,
                                  input logic cin);
        logic [128:0] s;
        exp_t e;
        if (op) s = {1'b0, a} - {1'b0, b} - {128'd0, cin};
        else    s = {1'b0, a} + {1'b0, b} + {128'd0, cin};
        e.res  = s[127:0];
        e.cout = s[128];
        return e;
    endfunction

    function automatic exp_t ref1(input logic op, input logic [31:0] a, input logic [31:0] b,
                                  input logic cin);
        logic [32:0] s;
        exp_t e;
        if (op) s = {1'b0, a} - {1'b0, b} - {32'd0, cin};
        else    s = {1'b0, a} + {1'b0, b} + {32'd0, cin};
        e.res  = {96'd0, s[31:0]};
        e.cout = s[32];
        return e;
    endfunction

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [3:0] cin_seq;

    // Present a request at a negedge and return at the negedge after it is accepted.
    task automatic accept4(input logic op, input logic [127:0] a, input logic [127:0] b,
                           input logic cin);
        int n = 0;
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_cin   = cin;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("accept_timeout", 128'd0, 128'd1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Full transaction on the 4-limb instance, holding rsp_ready low for 'hold' DONE cycles.
    task automatic op4(input logic op, input logic [127:0] a, input logic [127:0] b,
                       input logic cin, input int hold);
        exp_t e;
        int   lat;
        rsp_ready = 1'b1;   // high during RUN must not matter
        accept4(op, a, b, cin);
        q4.push_back(ref4(op, a, b, cin));
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            if (lat < 4) begin
                check("alu_sel", 128'(alu_sel), 128'({3'b000, op}));
                check("alu_a", 128'(alu_a), 128'(a[lat*32 +: 32]));
                check("alu_b", 128'(alu_b), 128'(b[lat*32 +: 32]));
                cin_seq[lat] = alu_cin;
            end
            @(negedge clk);
            lat++;
        end
        check("latency", 128'(lat), 128'd4);
        for (int i = 0; i < hold; i++) begin
            rsp_ready = 1'b0;
            req_valid = (i == 2);
            req_op    = 1'b1;
            req_a     = '1;
            req_b     = '1;
            req_cin   = 1'b1;
            check("hold_req_ready", 128'(req_ready), 128'd0);
            check("hold_valid", 128'(rsp_valid), 128'd1);
            check("hold_result", rsp_result, q4[0].res);
            check("hold_cout", 128'(rsp_cout), 128'(q4[0].cout));
            @(negedge clk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        e = q4.pop_front();
        check("rsp_result", rsp_result, e.res);
        check("rsp_cout", 128'(rsp_cout), 128'(e.cout));
        @(negedge clk);
        check("post_req_ready", 128'(req_ready), 128'd1);
        check("post_rsp_valid", 128'(rsp_valid), 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   lat;
        int   seen;

        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_op       = 1'b0;
        req_a        = '0;
        req_b        = '0;
        req_cin      = 1'b0;
        rsp_ready    = 1'b1;
        r1_req_valid = 1'b0;
        r1_req_op    = 1'b0;
        r1_req_a     = '0;
        r1_req_b     = '0;
        r1_req_cin   = 1'b0;
        r1_rsp_ready = 1'b1;
        cin_seq      = '0;

        repeat (2) @(negedge clk);
        check("rst_req_ready", 128'(req_ready), 128'd1);
        check("rst_rsp_valid", 128'(rsp_valid), 128'd0);
        check("rst_result", rsp_result, 128'd0);
        check("rst_cout", 128'(rsp_cout), 128'd0);
        check("rst_alu_a", 128'(alu_a), 128'd0);
        check("rst_alu_sel", 128'(alu_sel), 128'd0);
        check("rst_alu_cin", 128'(alu_cin), 128'd0);
        check("rst1_req_ready", 128'(r1_req_ready), 128'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: all-ones + 1 overflows to zero with carry out
        op4(1'b0, '1, 128'd1, 1'b0, 0);

        // 2: 0 - 1 borrows through every limb
        op4(1'b1, 128'd0, 128'd1, 1'b0, 0);

        // 3: carry-in propagates into limb 1 only
        op4(1'b0, 128'h1_0000_0000, 128'hFFFF_FFFF, 1'b1, 0);
        check("cin_seq", 128'(cin_seq), 128'(4'b0011));

        // 4: DONE held under backpressure while a request is pulsed
        op4(1'b0, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                  128'hF000_0000_0000_0001_0000_0000_FFFF_FFFF, 1'b0, 10);

        // 5: reset after two RUN cycles aborts the operation
        accept4(1'b0, 128'd5, 128'd7, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_req_ready", 128'(req_ready), 128'd1);
        check("abort_rsp_valid", 128'(rsp_valid), 128'd0);
        check("abort_result", rsp_result, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("abort_no_rsp", 128'(seen), 128'd0);
        op4(1'b0, 128'd5, 128'd7, 1'b0, 0);

        // 6: single-limb instance
        r1_req_valid = 1'b1;
        r1_req_op    = 1'b0;
        r1_req_a     = 32'hFFFF_FFFF;
        r1_req_b     = 32'd1;
        r1_req_cin   = 1'b0;
        lat = 0;
        while (!r1_req_ready && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        @(negedge clk);
        r1_req_valid = 1'b0;
        q1.push_back(ref1(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0));
        lat = 0;
        while (!r1_rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("w1_latency", 128'(lat), 128'd1);
        e = q1.pop_front();
        check("w1_result", 128'(r1_rsp_result), e.res);
        check("w1_cout", 128'(r1_rsp_cout), 128'(e.cout));
        @(negedge clk);
        check("w1_post_valid", 128'(r1_rsp_valid), 128'd0);

        // Random mixed add/sub traffic on the 4-limb instance
        for (int k = 0; k < 6; k++) begin
            logic [127:0] ra, rb;
            ra = {$urandom, $urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom, $urandom};
            op4(1'($urandom_range(0, 1)), ra, rb, 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
